// File: rtl/rv32_pkg.sv
// Shared RV32 core types plus the machine-mode interrupt controller's CSR map and states.
package rv32_pkg;

    typedef logic [31:0] rv32_pc_cnt_t;

    typedef enum logic [2:0] {
        RV32_OP_ALU,
        RV32_OP_LOAD,
        RV32_OP_STORE,
        RV32_OP_BRANCH,
        RV32_OP_JAL,
        RV32_OP_SYSTEM,
        RV32_MRET
    } rv32_opcode_enum_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } irq_evt_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    typedef enum logic [1:0] {
        IRQ_IDLE,
        IRQ_TRAP,
        IRQ_HANDLER
    } rv32_irq_state_t;

endpackage

// File: rtl/rv32_irq_prio_enc.sv
// Fixed-priority encoder: lowest set bit of the pending vector wins.
module rv32_irq_prio_enc #(
    parameter int unsigned NUM_IRQ = 8
) (
    input  logic [NUM_IRQ-1:0] pend,
    output logic               any,
    output logic [3:0]         idx
);

    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (pend[i] && !any) begin
                any = 1'b1;
                idx = 4'(i);
            end
        end
    end

endmodule

// File: rtl/rv32_irq_ctrl.sv
// Machine-mode local interrupt controller: CSR file, pending latch and trap/MRET sequencing.
module rv32_irq_ctrl
    import rv32_pkg::*;
#(
    parameter int unsigned NUM_IRQ     = 8,
    parameter logic [31:0] RESET_MTVEC = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic              rv32_retire,
    input  rv32_opcode_enum_t rv32_instr_opcode,
    input  rv32_pc_cnt_t      rv32_resume_pc,
    input  logic              csr_we,
    input  logic [11:0]       csr_addr,
    input  logic [31:0]       csr_wdata,
    output logic [31:0]       csr_rdata,
    output irq_evt_t          csr_irq_evt,
    output logic              irq_in_handler
);

    rv32_irq_state_t    state_q, state_d;
    logic [NUM_IRQ-1:0] irq_q, mip_q, mie_q, pend, clear_mask;
    logic               mstatus_mie_q, mstatus_mpie_q;
    logic [31:0]        mtvec_q, mepc_q, mcause_q, trap_base, trap_target;
    logic [3:0]         idx, trap_idx_q;
    logic               any, take, mret;

    assign pend = mip_q & mie_q;

    rv32_irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio_enc (
        .pend (pend),
        .any  (any),
        .idx  (idx)
    );

    // Trap beats MRET; neither is honoured while the TRAP cycle is in flight.
    assign take       = (state_q != IRQ_TRAP) && rv32_retire && mstatus_mie_q && any;
    assign mret       = (state_q != IRQ_TRAP) && rv32_retire &&
                        (rv32_instr_opcode == RV32_MRET) && !take;
    assign clear_mask = take ? (NUM_IRQ'(1) << idx) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IRQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IRQ_IDLE:    if (take) state_d = IRQ_TRAP;
            IRQ_TRAP:    state_d = IRQ_HANDLER;
            IRQ_HANDLER: begin
                if (take)      state_d = IRQ_TRAP;
                else if (mret) state_d = IRQ_IDLE;
            end
            default:     state_d = IRQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q          <= '0;
            mip_q          <= '0;
            mie_q          <= '0;
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mtvec_q        <= RESET_MTVEC;
            mepc_q         <= '0;
            mcause_q       <= '0;
            trap_idx_q     <= '0;
        end else begin
            irq_q <= irq_src;
            mip_q <= (mip_q & ~clear_mask) | (irq_src & ~irq_q);
            if (csr_we && csr_addr == CSR_MIE)   mie_q   <= csr_wdata[NUM_IRQ-1:0];
            if (csr_we && csr_addr == CSR_MTVEC) mtvec_q <= csr_wdata;
            if (take) begin
                mepc_q         <= rv32_resume_pc;
                mcause_q       <= {1'b1, 31'(32'd16 + 32'(idx))};
                mstatus_mpie_q <= mstatus_mie_q;
                mstatus_mie_q  <= 1'b0;
                trap_idx_q     <= idx;
            end else begin
                if (csr_we && csr_addr == CSR_MSTATUS) begin
                    mstatus_mie_q  <= csr_wdata[3];
                    mstatus_mpie_q <= csr_wdata[7];
                end
                if (csr_we && csr_addr == CSR_MEPC)   mepc_q   <= {csr_wdata[31:2], 2'b00};
                if (csr_we && csr_addr == CSR_MCAUSE) mcause_q <= csr_wdata;
                if (mret) begin
                    mstatus_mie_q  <= mstatus_mpie_q;
                    mstatus_mpie_q <= 1'b1;
                end
            end
        end
    end

    assign trap_base   = {mtvec_q[31:2], 2'b00};
    assign trap_target = (mtvec_q[1:0] == 2'b01) ?
                         trap_base + ((32'd16 + 32'(trap_idx_q)) << 2) : trap_base;

    always_comb begin
        csr_irq_evt.valid = (state_q == IRQ_TRAP);
        csr_irq_evt.data  = (state_q == IRQ_TRAP) ? trap_target : mepc_q;
    end

    assign irq_in_handler = (state_q == IRQ_HANDLER);

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            CSR_MSTATUS: csr_rdata = {24'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
            CSR_MIE:     csr_rdata = 32'(mie_q);
            CSR_MTVEC:   csr_rdata = mtvec_q;
            CSR_MEPC:    csr_rdata = mepc_q;
            CSR_MCAUSE:  csr_rdata = mcause_q;
            CSR_MIP:     csr_rdata = 32'(mip_q);
            default:     csr_rdata = '0;
        endcase
    end

endmodule

// File: doc/rv32_irq_ctrl.md
RV32_IRQ_CTRL -- requirements
Module: rv32_irq_ctrl

Interface
REQ-001 Parameter NUM_IRQ, default 8, SHALL set the number of local interrupt sources (1..16).
REQ-002 Parameter RESET_MTVEC, default 32'h0, SHALL set the reset value of MTVEC.
REQ-003 Ports SHALL be, one per line:
  clk  input  1  single clock.
  rst  input  1  asynchronous, active-high reset.
  irq_src  input  NUM_IRQ  level interrupt lines, synchronous to clk.
  rv32_retire  input  1  one instruction retires this cycle.
  rv32_instr_opcode  input  rv32_opcode_enum_t  opcode of the retiring instruction.
  rv32_resume_pc  input  rv32_pc_cnt_t  PC the core would fetch after the retiring instruction.
  csr_we  input  1  CSR write strobe.
  csr_addr  input  12  CSR address.
  csr_wdata  input  32  CSR write data.
  csr_rdata  output  32  CSR read data, combinational from csr_addr.
  csr_irq_evt  output  irq_evt_t  {valid, data} toward the next-PC logic.
  irq_in_handler  output  1  high while state is HANDLER.

Function
REQ-004 CSRs SHALL be MSTATUS 0x300 (bit3 MIE, bit7 MPIE), MIE 0x304, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342, MIP 0x344 (read-only); unmapped addresses SHALL read 0 and ignore writes.
REQ-005 MIP[i] SHALL set on a 0->1 transition of irq_src[i] (one-cycle edge-detect register) and clear only when interrupt i is taken; set SHALL win over clear in the same cycle.
REQ-006 Enabled-pending vector SHALL be MIP & MIE[NUM_IRQ-1:0]; the lowest index SHALL have highest priority.
REQ-007 FSM states SHALL be IDLE, TRAP, HANDLER.
REQ-008 A trap SHALL be taken from IDLE or HANDLER when rv32_retire=1, MSTATUS.MIE=1 and the enabled-pending vector is non-zero.
REQ-009 On taking a trap, at that clock edge: state<=TRAP; MEPC<=rv32_resume_pc; MCAUSE<={1'b1, 31'(16+i)}; MPIE<=MIE; MIE<=0; MIP[i] cleared.
REQ-010 In TRAP, csr_irq_evt.valid SHALL be 1 for exactly one cycle, after which state<=HANDLER unconditionally.
REQ-011 Trap target SHALL be {MTVEC[31:2],2'b00} when MTVEC[1:0]=0, and {MTVEC[31:2],2'b00}+4*(16+i) when MTVEC[1:0]=1; other modes SHALL behave as mode 0.
REQ-012 csr_irq_evt.data SHALL equal the trap target while valid=1 and MEPC otherwise, so MRET redirection reads MEPC.
REQ-013 Retire with opcode RV32_MRET SHALL set MIE<=MPIE and MPIE<=1; from HANDLER, state<=IDLE; from IDLE, state stays IDLE.
REQ-014 In TRAP, retire and MRET SHALL be ignored and no new trap SHALL be taken.
REQ-015 If a trap and an MRET qualify in the same cycle, the trap SHALL win and the MRET side effects SHALL be dropped.
REQ-016 A CSR write coinciding with a trap SHALL be discarded for MSTATUS, MEPC and MCAUSE; writes to other CSRs SHALL complete.
REQ-017 Written values: MEPC[1:0] forced to 0; MIE bits at or above NUM_IRQ read 0; MSTATUS bits other than 3 and 7 read 0.

Reset
REQ-018 Asserting rst SHALL asynchronously set: state=IDLE; MSTATUS=0; MIE=0; MIP=0; edge register=0; MEPC=0; MCAUSE=0; MTVEC=RESET_MTVEC.
REQ-019 During reset, csr_irq_evt SHALL be {0,0}, irq_in_handler=0 and csr_rdata SHALL reflect the reset CSR values.
REQ-020 Reset asserted while in TRAP SHALL abort the trap, with no valid pulse after reset release.

Structure
REQ-021 CSR address constants and the state enum rv32_irq_state_t SHALL be added to rv32_pkg; irq_evt_t SHALL stay in rv32_pkg.
REQ-022 Sub-module rv32_irq_prio_enc SHALL hold the priority encoding (pending vector -> {any, index}).

Verification
REQ-023 Direct vector: MTVEC=0x100, MIE=0x1, MSTATUS.MIE=1; pulse irq_src[0]; retire with resume_pc 0x40 -> next cycle valid=1, data=0x100; MEPC=0x40; MCAUSE=0x80000010.
REQ-024 Vectored mode: MTVEC=0x201; irq_src[2] taken -> data=0x200+4*18=0x248; MCAUSE=0x80000012.
REQ-025 Priority: irq_src[3] and irq_src[1] rise together, both enabled -> cause 17 taken first; MIP[3] stays set; after MRET re-enables MIE, the next retire takes cause 19.
REQ-026 MRET: in HANDLER, retire RV32_MRET -> state IDLE, MSTATUS.MIE=1, csr_irq_evt.data=MEPC, valid=0.
REQ-027 Masked: MSTATUS.MIE=0 with MIP pending -> no valid pulse; writing MSTATUS=0x8 followed by a retire -> trap taken.
REQ-028 Reset mid-trap: assert rst during the TRAP cycle -> valid=0, MIP=0, state IDLE after release.
